// File: rtl/alu_multicycle.sv
// Clocked ALU with a Start/Busy/Done handshake. Most operations finish in a single cycle.
// MUL (shift-add) and MOD/DIV (restoring division) iterate for WIDTH clocks.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult1,
    output logic [WIDTH-1:0] ALUResult2,
    output logic             Zero,
    output logic             DivByZero
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MOD = 4'h2, OP_MUL = 4'h3,
        OP_SLL = 4'h4, OP_SRL = 4'h5, OP_OR  = 4'h6, OP_AND = 4'h7,
        OP_XOR = 4'h8, OP_DIV = 4'h9, OP_SLT = 4'hA
    } alu_op_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
    logic               is_mod_q, is_mod_d;
    logic               done_q, done_d, zero_q, zero_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   r1_q, r1_d, r2_q, r2_d;

    alu_op_e            op;
    logic [WIDTH-1:0]   sc_r1, sc_r2;
    logic               sc_dbz, go_iter;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;

    assign op      = alu_op_e'(ALUControl);
    assign go_iter = (op == OP_MUL) || ((op == OP_MOD || op == OP_DIV) && B != '0);

    // Single-cycle results; MOD/DIV here only cover the B == 0 case.
    always_comb begin
        sc_r1  = '0;
        sc_r2  = '0;
        sc_dbz = 1'b0;
        case (op)
            OP_ADD: sc_r1 = A + B;
            OP_SUB: sc_r1 = A - B;
            OP_SLL: sc_r1 = A << B[SHAMT_W-1:0];
            OP_SRL: sc_r1 = A >> B[SHAMT_W-1:0];
            OP_OR:  sc_r1 = A | B;
            OP_AND: sc_r1 = A & B;
            OP_XOR: sc_r1 = A ^ B;
            OP_SLT: sc_r1 = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_MOD: begin
                sc_r1  = A;
                sc_r2  = '1;
                sc_dbz = 1'b1;
            end
            OP_DIV: begin
                sc_r1  = '1;
                sc_r2  = A;
                sc_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    // acc holds product high half / partial remainder; mq holds multiplier / quotient bits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_mod_d = is_mod_q;
        done_d   = 1'b0;
        r1_d     = r1_q;
        r2_d     = r2_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;

        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (go_iter) begin
                        state_d  = (op == OP_MUL) ? S_MUL : S_DIV;
                        is_mod_d = (op == OP_MOD);
                        opnd_d   = B;
                        acc_d    = '0;
                        mq_d     = A;
                        cnt_d    = '0;
                    end else begin
                        done_d = 1'b1;
                        r1_d   = sc_r1;
                        r2_d   = sc_r2;
                        zero_d = (sc_r1 == '0);
                        dbz_d  = sc_dbz;
                    end
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == S_MUL) begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    if (state_q == S_MUL || !is_mod_q) begin
                        r1_d = mq_d;
                        r2_d = acc_d;
                    end else begin
                        r1_d = acc_d;
                        r2_d = mq_d;
                    end
                    zero_d = (r1_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            is_mod_q <= 1'b0;
            done_q   <= 1'b0;
            r1_q     <= '0;
            r2_q     <= '0;
            zero_q   <= 1'b1;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            is_mod_q <= is_mod_d;
            done_q   <= done_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = done_q;
    assign ALUResult1 = r1_q;
    assign ALUResult2 = r2_q;
    assign Zero       = zero_q;
    assign DivByZero  = dbz_q;
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised, clocked successor to the team's 32-bit combinational ALU. It keeps the same ALUControl operation codes and adds divide and set-less-than. Multiply, mod and divide run as iterative multi-cycle operations (shift-add and restoring division). All results are registered and delivered through a Start/Busy/Done handshake, so the block sits between the EX-stage control and the register-file write-back.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 4 and a power of two.
SHAMT_W, $clog2(WIDTH), localparam; number of low bits of B used as the shift amount.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only when Busy=0.
ALUControl  input  4  operation code, captured with Start.
A  input  WIDTH  operand A, captured with Start.
B  input  WIDTH  operand B, captured with Start.
Busy  output  1  high while a multi-cycle operation iterates.
Done  output  1  one-cycle pulse: ALUResult1/ALUResult2/Zero/DivByZero were updated this cycle.
ALUResult1  output  WIDTH  primary result.
ALUResult2  output  WIDTH  secondary result: product high half, or quotient/remainder.
Zero  output  1  1 when ALUResult1 == 0, registered with the result.
DivByZero  output  1  1 when the last completed MOD/DIV had B == 0.

Behaviour:
- Reset (Reset=1 at an edge, from any state, including mid-operation): state IDLE, Busy=0, Done=0, ALUResult1=0, ALUResult2=0, Zero=1, DivByZero=0, iteration counter=0. Any in-flight operation is discarded.
- States: IDLE, MUL, DIV. Done is a registered pulse, not a state.
- IDLE with Start=1: latch ALUControl, A and B.
  - Single-cycle ops: results written at that same edge; Done=1 for exactly the next cycle; stay in IDLE.
  - 0011 (MUL): go to MUL.
  - 0010 (MOD), 1001 (DIV) with B!=0: go to DIV.
  - MUL/DIV entry: Busy=1 and counter=0.
- MUL/DIV: one iteration per clock for WIDTH clocks. At the WIDTH-th edge: write results, set Busy=0 and Done=1, return to IDLE. Done is visible WIDTH+1 clocks after Start was sampled.
- Start while Busy=1 is ignored, and the inputs are not re-latched. Changing A, B or ALUControl during Busy has no effect.
- Back-to-back: Start=1 in the Done cycle is accepted (Busy is already 0).
- Outputs hold their last values until the next completion. Done=0 in every cycle except the completion cycle.
- Arithmetic, all unsigned and modulo 2^WIDTH unless stated. ALUResult2=0 unless stated.
  - 0000 ADD: A+B.
  - 0001 SUB: A-B.
  - 0010 MOD: R1=A mod B, R2=A/B.
  - 0011 MUL: full 2*WIDTH product; R1=low half, R2=high half.
  - 0100 SLL: A << B[SHAMT_W-1:0].
  - 0101 SRL: A >> B[SHAMT_W-1:0], logical (zero fill).
  - 0110 OR, 0111 AND, 1000 XOR: bitwise.
  - 1001 DIV: R1=A/B, R2=A mod B.
  - 1010 SLT: R1=1 if signed(A) < signed(B), else 0.
  - 1011-1111: R1=0, R2=0, single-cycle Done.
- Divide by zero (MOD or DIV with B==0): single-cycle, no DIV state.
  - DIV: R1=all ones, R2=A.
  - MOD: R1=A, R2=all ones.
  - DivByZero=1.
  - Every other completion clears DivByZero.
- Zero always reflects the ALUResult1 written at the same edge.

Test Plan:
1. WIDTH=32, ADD A=2,B=2 -> Done 1 clk after Start, R1=4, Zero=0. SUB A=2,B=2 -> R1=0, Zero=1. SUB A=2,B=3 -> R1=0xFFFFFFFF.
2. MUL A=64,B=4 -> Busy for 32 clks, Done at clk 33, R1=256, R2=0. MUL A=B=0xFFFFFFFF -> R1=0x00000001, R2=0xFFFFFFFE.
3. MOD A=4,B=3 -> Done at clk 33, R1=1, R2=1. DIV A=100,B=7 -> R1=14, R2=2. DIV A=5,B=0 -> Done at clk 1, R1=0xFFFFFFFF, R2=5, DivByZero=1; a following ADD clears DivByZero.
4. Logic and shift: OR A=0x0F0F0F0F,B=0xF0F0F0F0 -> 0xFFFFFFFF. AND of the same -> 0, Zero=1. XOR A=0xAAAAAAAA,B=0xF0F0F0F0 -> 0x5A5A5A5A. SLL A=1,B=0x25 -> 0x20 (shamt 5). SRL A=0x80000000,B=31 -> 1. SLT A=0xFFFFFFFF,B=1 -> 1.
5. Start MUL, pulse Start with ADD at clk 5 -> ignored, MUL completes normally. Start a new MUL in the Done cycle -> accepted. Assert Reset at clk 10 of a DIV -> next cycle Busy=0, Done=0, R1=R2=0, Zero=1, and no Done pulse follows.
6. WIDTH=16 instance: MUL 0xFFFF*0xFFFF -> Done at clk 17, R1=0x0001, R2=0xFFFE. SLL A=1,B=0x13 -> 0x0008. Illegal code 1100 -> R1=0, Zero=1, Done at clk 1.
